// File: rtl/status_mon_pkg.sv
// Shared types and helpers for the status event monitor.
// Holds the FSM state encoding and the saturating increment used by the report counter.
package status_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_REPORT
    } mon_state_t;

    localparam int SAT_W = 32;

    typedef struct packed {
        logic [SAT_W-1:0] cnt;
        logic             sat;
    } sat_inc_t;

    // Increment that sticks at max; sat flags an edge arriving while already at max.
    function automatic sat_inc_t sat_inc(input logic [SAT_W-1:0] count,
                                         input logic [SAT_W-1:0] max);
        sat_inc_t r;
        if (count >= max) begin
            r.cnt = max;
            r.sat = 1'b1;
        end else begin
            r.cnt = count + 1'b1;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/status_edge_det.sv
// Rising-edge detector on the monitored status, optional 2-flop synchronizer (STATUS_SYNC_EN).
// Latency: 0 cycles without sync, 2 cycles with sync.
// Backpressure: none; rise_o is a per-cycle strobe.
module status_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic s;
    logic s_prev;

`ifdef STATUS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign s = sync_q[1];
`else
    assign s = d_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

    assign rise_o = s & ~s_prev;

endmodule

// File: rtl/status_event_monitor.sv
// Counts status rising edges over a WIN_LEN-cycle window and reports the count (STATUS_SYNC_EN adds a synchronizer).
// Latency: start sampled in cycle 0, window in cycles 1..WIN_LEN, rpt_valid_o from cycle WIN_LEN+1.
// Backpressure: report held stable until rpt_ready_i; window requests are dropped while busy.
module status_event_monitor
    import status_mon_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             status_i,
    input  logic             win_start_i,
    input  logic             rpt_ready_i,
    output logic             rpt_valid_o,
    output logic [CNT_W-1:0] rpt_count_o,
    output logic             rpt_sat_o,
    output logic             busy_o
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mon_state_t       state, state_nxt;
    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             sat, sat_nxt;
    logic             rise;
    sat_inc_t         inc;
    logic             unused_inc_hi;

    status_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (status_i),
        .rise_o (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
            count   <= '0;
            sat     <= 1'b0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
            count   <= count_nxt;
            sat     <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        count_nxt   = count;
        sat_nxt     = sat;
        inc         = sat_inc(SAT_W'(count), SAT_W'(CNT_MAX));
        case (state)
            ST_IDLE: begin
                if (win_start_i) begin
                    state_nxt   = ST_COUNT;
                    win_cnt_nxt = WIN_LAST;
                    count_nxt   = '0;
                    sat_nxt     = 1'b0;
                end
            end
            ST_COUNT: begin
                if (rise) begin
                    count_nxt = inc.cnt[CNT_W-1:0];
                    sat_nxt   = sat | inc.sat;
                end
                // The edge in the final window cycle is still counted above.
                if (win_cnt == '0) begin
                    state_nxt = ST_REPORT;
                end else begin
                    win_cnt_nxt = win_cnt - 1'b1;
                end
            end
            ST_REPORT: begin
                if (rpt_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign unused_inc_hi = ^inc.cnt[SAT_W-1:CNT_W];

    assign rpt_valid_o = (state == ST_REPORT);
    assign busy_o      = (state != ST_IDLE);
    assign rpt_count_o = count;
    assign rpt_sat_o   = sat;

endmodule

// File: tb/tb_status_event_monitor.sv
// Directed bench for status_event_monitor: one instance with CNT_W=4 and one with CNT_W=2 share stimulus.
module tb_status_event_monitor;

    logic       clk;
    logic       rst_n;
    logic       status_i;
    logic       win_start_i;
    logic       rpt_ready_i;

    logic       valid4, sat4, busy4;
    logic [3:0] count4;
    logic       valid2, sat2, busy2;
    logic [1:0] count2;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef STATUS_SYNC_EN
    localparam int EXP_TOG4  = 7;
    localparam int EXP_LAST  = 0;
    localparam int EXP_HOLD  = 1;
`else
    localparam int EXP_TOG4  = 8;
    localparam int EXP_LAST  = 1;
    localparam int EXP_HOLD  = 1;
`endif

    status_event_monitor #(.WIN_LEN(16), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .status_i    (status_i),
        .win_start_i (win_start_i),
        .rpt_ready_i (rpt_ready_i),
        .rpt_valid_o (valid4),
        .rpt_count_o (count4),
        .rpt_sat_o   (sat4),
        .busy_o      (busy4)
    );

    status_event_monitor #(.WIN_LEN(16), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .status_i    (status_i),
        .win_start_i (win_start_i),
        .rpt_ready_i (rpt_ready_i),
        .rpt_valid_o (valid2),
        .rpt_count_o (count2),
        .rpt_sat_o   (sat2),
        .busy_o      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat[c] is status_i during window cycle c (cycle 0 = start request); runs through cycle last.
    task automatic run_window(input logic [16:0] pat, input int last);
        status_i    = 1'b0;
        win_start_i = 1'b0;
        rpt_ready_i = 1'b0;
        repeat (3) step();
        win_start_i = 1'b1;
        status_i    = pat[0];
        step();
        win_start_i = 1'b0;
        for (int c = 1; c <= last; c++) begin
            status_i = pat[c];
            step();
        end
    endtask

    task automatic finish_report();
        rpt_ready_i = 1'b1;
        step();
        rpt_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        status_i    = 1'b0;
        win_start_i = 1'b0;
        rpt_ready_i = 1'b0;
        #1;
        n_cmp++;
        if ({valid4, count4, sat4, busy4} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs4: got %b want 0000000", {valid4, count4, sat4, busy4});
        end
        n_cmp++;
        if ({valid2, count2, sat2, busy2} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs2: got %b want 00000", {valid2, count2, sat2, busy2});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_count_window();
        run_window(17'h15554, 15);
        n_cmp++;
        if (valid4 !== 1'b0 || busy4 !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_before: valid=%b busy=%b want valid=0 busy=1", valid4, busy4);
        end
        status_i = 1'b1;
        step();
        n_cmp++;
        if (valid4 !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_valid: valid=%b want 1", valid4);
        end
        n_cmp++;
        if (count4 !== 4'(EXP_TOG4) || sat4 !== 1'b0) begin
            n_bad++;
            $display("FAIL toggle_count4: count=%0d sat=%b want count=%0d sat=0", count4, sat4, EXP_TOG4);
        end
        finish_report();
    endtask

    task automatic test_saturation();
        run_window(17'h15554, 16);
        n_cmp++;
        if (valid2 !== 1'b1 || count2 !== 2'd3 || sat2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_count2: valid=%b count=%0d sat=%b want 1 3 1", valid2, count2, sat2);
        end
        finish_report();
    endtask

    task automatic test_backpressure();
        run_window(17'h15554, 16);
        for (int i = 0; i < 5; i++) begin
            win_start_i = 1'b1;
            step();
            n_cmp++;
            if (valid4 !== 1'b1 || count4 !== 4'(EXP_TOG4) || busy4 !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_report[%0d]: valid=%b count=%0d busy=%b want 1 %0d 1",
                         i, valid4, count4, busy4, EXP_TOG4);
            end
        end
        // Start request coincident with the handshake must be dropped.
        rpt_ready_i = 1'b1;
        win_start_i = 1'b1;
        step();
        rpt_ready_i = 1'b0;
        win_start_i = 1'b0;
        n_cmp++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0 || count4 !== 4'(EXP_TOG4)) begin
            n_bad++;
            $display("FAIL handshake_idle: valid=%b busy=%b count=%0d want 0 0 %0d",
                     valid4, busy4, count4, EXP_TOG4);
        end
        step();
        n_cmp++;
        if (busy4 !== 1'b0 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL no_queued_window: busy4=%b busy2=%b want 0 0", busy4, busy2);
        end
    endtask

    task automatic test_abort();
        run_window(17'h15554, 7);
        n_cmp++;
        if (busy4 !== 1'b1 || count4 === 4'd0) begin
            n_bad++;
            $display("FAIL pre_abort: busy=%b count=%0d want busy=1 count>0", busy4, count4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({valid4, count4, sat4, busy4} !== 7'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b want 0000000", {valid4, count4, sat4, busy4});
        end
        step();
        rst_n = 1'b1;
        repeat (20) begin
            step();
            n_cmp++;
            if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_report: valid=%b busy=%b want 0 0", valid4, busy4);
            end
        end
        run_window(17'h1FFFE, 16);
        n_cmp++;
        if (valid4 !== 1'b1 || count4 !== 4'(EXP_HOLD) || count2 !== 2'(EXP_HOLD)) begin
            n_bad++;
            $display("FAIL hold_high_count: valid=%b count4=%0d count2=%0d want 1 %0d %0d",
                     valid4, count4, count2, EXP_HOLD, EXP_HOLD);
        end
        finish_report();
    endtask

    task automatic test_edge_timing();
        run_window(17'h10000, 16);
        n_cmp++;
        if (valid4 !== 1'b1 || count4 !== 4'(EXP_LAST) || sat4 !== 1'b0) begin
            n_bad++;
            $display("FAIL last_cycle_edge: valid=%b count=%0d sat=%b want 1 %0d 0",
                     valid4, count4, sat4, EXP_LAST);
        end
        finish_report();
        run_window(17'h02000, 16);
        n_cmp++;
        if (valid4 !== 1'b1 || count4 !== 4'd1) begin
            n_bad++;
            $display("FAIL early_edge: valid=%b count=%0d want 1 1", valid4, count4);
        end
        finish_report();
    endtask

    initial begin
        test_reset();
        test_count_window();
        test_saturation();
        test_backpressure();
        test_abort();
        test_edge_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
